ahb_arb_3m1s: RTL and testbench

Round-robin AHB-Lite arbiter that shares one slave port among three masters, e.g. three bus masters contending for a single memory or bridge. A master's address phase is never refused. If that master is not currently granted, its address phase is captured into a per-master pending register, and the master is stalled with HREADY low until the captured transfer is issued. The block is a drop-in upgrade path wherever a two-master mux is too narrow or needs fairness.

---
 rtl/ahb_arb_3m1s.sv | 215 +++++++++++++++++++++
 tb/tb_ahb_arb_3m1s.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arb_3m1s.sv
// Three-master AHB-Lite arbiter onto one slave: non-granted requests are captured and replayed.
// Define AHB_ARB_FIXED_PRIO_EN for fixed M0 > M1 > M2 owner selection instead of round-robin.
module ahb_arb_3m1s #(
  parameter int SZ = 64
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [31:0]   HADDR_M0,
  input  logic [1:0]    HTRANS_M0,
  input  logic          HWRITE_M0,
  input  logic [2:0]    HSIZE_M0,
  input  logic [SZ-1:0] HWDATA_M0,
  output logic          HREADY_M0,
  output logic [SZ-1:0] HRDATA_M0,
  input  logic [31:0]   HADDR_M1,
  input  logic [1:0]    HTRANS_M1,
  input  logic          HWRITE_M1,
  input  logic [2:0]    HSIZE_M1,
  input  logic [SZ-1:0] HWDATA_M1,
  output logic          HREADY_M1,
  output logic [SZ-1:0] HRDATA_M1,
  input  logic [31:0]   HADDR_M2,
  input  logic [1:0]    HTRANS_M2,
  input  logic          HWRITE_M2,
  input  logic [2:0]    HSIZE_M2,
  input  logic [SZ-1:0] HWDATA_M2,
  output logic          HREADY_M2,
  output logic [SZ-1:0] HRDATA_M2,
  input  logic          HREADY,
  input  logic [SZ-1:0] HRDATA,
  output logic [31:0]   HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [SZ-1:0] HWDATA
);

  logic [31:0]   m_addr  [3];
  logic [1:0]    m_trans [3];
  logic [2:0]    m_write;
  logic [2:0]    m_size  [3];
  logic [SZ-1:0] m_wdata [3];

  assign m_addr[0]  = HADDR_M0;
  assign m_addr[1]  = HADDR_M1;
  assign m_addr[2]  = HADDR_M2;
  assign m_trans[0] = HTRANS_M0;
  assign m_trans[1] = HTRANS_M1;
  assign m_trans[2] = HTRANS_M2;
  assign m_write    = {HWRITE_M2, HWRITE_M1, HWRITE_M0};
  assign m_size[0]  = HSIZE_M0;
  assign m_size[1]  = HSIZE_M1;
  assign m_size[2]  = HSIZE_M2;
  assign m_wdata[0] = HWDATA_M0;
  assign m_wdata[1] = HWDATA_M1;
  assign m_wdata[2] = HWDATA_M2;

  logic [1:0]  grant_q, grant_d;
  logic [1:0]  downer_q, downer_d;
  logic        dvalid_q, dvalid_d;
  logic [2:0]  pend_v;
  logic [2:0]  pend_v_nx;
  logic [2:0]  hready_m;
  logic [2:0]  cap;
  logic [2:0]  clr;
  logic [31:0] src_addr  [3];
  logic [1:0]  src_trans [3];
  logic [2:0]  src_write;
  logic [2:0]  src_size  [3];
  logic [31:0] g_addr;
  logic [1:0]  g_trans;
  logic        g_write;
  logic [2:0]  g_size;
  logic        req_src;
  logic        issue;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_m
      logic        v_q, v_d;
      logic [31:0] addr_q, addr_d;
      logic [1:0]  trans_q, trans_d;
      logic        write_q, write_d;
      logic [2:0]  size_q, size_d;

      assign src_addr[gi]  = v_q ? addr_q  : m_addr[gi];
      assign src_trans[gi] = v_q ? trans_q : m_trans[gi];
      assign src_write[gi] = v_q ? write_q : m_write[gi];
      assign src_size[gi]  = v_q ? size_q  : m_size[gi];

      assign hready_m[gi] = v_q ? 1'b0 :
                            (dvalid_q && (downer_q == 2'(gi))) ? HREADY : 1'b1;
      // A live transfer issued directly by the granted owner must not also be captured.
      assign cap[gi] = m_trans[gi][1] & hready_m[gi] &
                       ~((grant_q == 2'(gi)) & issue & ~v_q);
      assign clr[gi] = (grant_q == 2'(gi)) & issue & v_q;

      always_comb begin
        v_d     = cap[gi] | (v_q & ~clr[gi]);
        addr_d  = cap[gi] ? m_addr[gi]  : addr_q;
        trans_d = cap[gi] ? m_trans[gi] : trans_q;
        write_d = cap[gi] ? m_write[gi] : write_q;
        size_d  = cap[gi] ? m_size[gi]  : size_q;
      end

      always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
          v_q     <= 1'b0;
          addr_q  <= '0;
          trans_q <= 2'b00;
          write_q <= 1'b0;
          size_q  <= '0;
        end else begin
          v_q     <= v_d;
          addr_q  <= addr_d;
          trans_q <= trans_d;
          write_q <= write_d;
          size_q  <= size_d;
        end
      end

      assign pend_v[gi]    = v_q;
      assign pend_v_nx[gi] = v_d;
    end
  endgenerate

  always_comb begin
    g_addr  = '0;
    g_trans = 2'b00;
    g_write = 1'b0;
    g_size  = '0;
    case (grant_q)
      2'd0: begin
        g_addr = src_addr[0]; g_trans = src_trans[0]; g_write = src_write[0]; g_size = src_size[0];
      end
      2'd1: begin
        g_addr = src_addr[1]; g_trans = src_trans[1]; g_write = src_write[1]; g_size = src_size[1];
      end
      2'd2: begin
        g_addr = src_addr[2]; g_trans = src_trans[2]; g_write = src_write[2]; g_size = src_size[2];
      end
      default: ;
    endcase
  end

  assign req_src = g_trans[1];
  assign issue   = req_src & HREADY;
  assign HADDR   = req_src ? g_addr  : 32'h0;
  assign HTRANS  = req_src ? g_trans : 2'b00;
  assign HWRITE  = req_src ? g_write : 1'b0;
  assign HSIZE   = req_src ? g_size  : 3'b000;

  always_comb begin
    HWDATA = '0;
    if (dvalid_q) begin
      case (downer_q)
        2'd0:    HWDATA = m_wdata[0];
        2'd1:    HWDATA = m_wdata[1];
        2'd2:    HWDATA = m_wdata[2];
        default: HWDATA = '0;
      endcase
    end
  end

  assign HREADY_M0 = hready_m[0];
  assign HREADY_M1 = hready_m[1];
  assign HREADY_M2 = hready_m[2];
  assign HRDATA_M0 = HRDATA;
  assign HRDATA_M1 = HRDATA;
  assign HRDATA_M2 = HRDATA;

`ifdef AHB_ARB_FIXED_PRIO_EN
  function automatic logic [1:0] pick_next(input logic [1:0] cur, input logic [2:0] pv);
    if (pv[0])      pick_next = 2'd0;
    else if (pv[1]) pick_next = 2'd1;
    else if (pv[2]) pick_next = 2'd2;
    else            pick_next = cur;
  endfunction
`else
  // Search cur+1, cur+2; when nobody else is pending the owner stays parked.
  function automatic logic [1:0] pick_next(input logic [1:0] cur, input logic [2:0] pv);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = (cur == 2'd2) ? 2'd0 : cur + 2'd1;
    c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    if (pv[c1])      pick_next = c1;
    else if (pv[c2]) pick_next = c2;
    else             pick_next = cur;
  endfunction
`endif

  always_comb begin
    grant_d  = grant_q;
    dvalid_d = dvalid_q;
    downer_d = downer_q;
    if (HREADY) begin
      dvalid_d = issue;
      downer_d = grant_q;
      grant_d  = pick_next(grant_q, pend_v_nx);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_q  <= 2'd0;
      dvalid_q <= 1'b0;
      downer_q <= 2'd0;
    end else begin
      grant_q  <= grant_d;
      dvalid_q <= dvalid_d;
      downer_q <= downer_d;
    end
  end

endmodule

// File: tb/tb_ahb_arb_3m1s.sv
// Directed bench for ahb_arb_3m1s: scoreboard of expected slave address phases and write data.
module tb_ahb_arb_3m1s;
  localparam int SZ = 64;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [31:0]   m_addr  [3];
  logic [1:0]    m_trans [3];
  logic          m_write [3];
  logic [2:0]    m_size  [3];
  logic [SZ-1:0] m_wdata [3];
  logic [2:0]    hready_m;
  logic [SZ-1:0] m_rdata [3];
  logic          s_hready;
  logic [SZ-1:0] s_rdata;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [SZ-1:0] HWDATA;

  typedef struct {
    logic [31:0]   addr;
    logic          write;
    logic [SZ-1:0] wdata;
  } exp_t;

  exp_t          exp_q[$];
  int            checks   = 0;
  int            failures = 0;
  logic          wchk     = 1'b0;
  logic [SZ-1:0] wexp     = '0;

  ahb_arb_3m1s #(.SZ(SZ)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HADDR_M0(m_addr[0]), .HTRANS_M0(m_trans[0]), .HWRITE_M0(m_write[0]),
    .HSIZE_M0(m_size[0]), .HWDATA_M0(m_wdata[0]), .HREADY_M0(hready_m[0]), .HRDATA_M0(m_rdata[0]),
    .HADDR_M1(m_addr[1]), .HTRANS_M1(m_trans[1]), .HWRITE_M1(m_write[1]),
    .HSIZE_M1(m_size[1]), .HWDATA_M1(m_wdata[1]), .HREADY_M1(hready_m[1]), .HRDATA_M1(m_rdata[1]),
    .HADDR_M2(m_addr[2]), .HTRANS_M2(m_trans[2]), .HWRITE_M2(m_write[2]),
    .HSIZE_M2(m_size[2]), .HWDATA_M2(m_wdata[2]), .HREADY_M2(hready_m[2]), .HRDATA_M2(m_rdata[2]),
    .HREADY(s_hready), .HRDATA(s_rdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int m, input logic [1:0] t, input logic [31:0] a,
                     input logic w, input logic [SZ-1:0] d);
    m_trans[m] = t;
    m_addr[m]  = a;
    m_write[m] = w;
    m_size[m]  = 3'b010;
    m_wdata[m] = d;
  endtask

  task automatic push(input logic [31:0] a, input logic w, input logic [SZ-1:0] d);
    exp_t e;
    e.addr  = a;
    e.write = w;
    e.wdata = d;
    exp_q.push_back(e);
  endtask

  task automatic cyc;
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle;
    @(negedge HCLK);
  endtask

  // Scoreboard: every slave address phase accepted must match the next expected entry;
  // write data is checked in the following cycle.
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      wchk <= 1'b0;
    end else begin
      if (wchk) chk("hwdata", 64'(HWDATA), 64'(wexp));
      wchk <= 1'b0;
      if (HTRANS[1] && s_hready) begin
        if (exp_q.size() == 0) begin
          chk("issue_expected", 64'(exp_q.size()), 64'd1);
        end else begin
          $display("issue addr=%08h write=%0d", HADDR, HWRITE);
          chk("haddr", 64'(HADDR), 64'(exp_q[0].addr));
          chk("hwrite", 64'(HWRITE), 64'(exp_q[0].write));
          chk("hsize", 64'(HSIZE), 64'(3'b010));
          if (exp_q[0].write) begin
            wchk <= 1'b1;
            wexp <= exp_q[0].wdata;
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx [2];
    HRESETn  = 1'b0;
    s_hready = 1'b1;
    s_rdata  = 64'h1234_5678_9ABC_DEF0;
    for (int m = 0; m < 3; m++) drv(m, 2'b00, 32'h0, 1'b0, '0);

    // Reset state, including M0 mirrored onto the slave while in reset.
    cyc;
    cyc;
    chk("rst_hready_m", 64'(hready_m), 64'(3'b111));
    chk("rst_htrans", 64'(HTRANS), 64'(2'b00));
    chk("rst_hwdata", 64'(HWDATA), 64'(0));
    drv(0, 2'b10, 32'h55, 1'b0, '0);
    #1;
    chk("rst_mirror_htrans", 64'(HTRANS), 64'(2'b10));
    chk("rst_mirror_haddr", 64'(HADDR), 64'(32'h55));
    drv(0, 2'b00, 32'h0, 1'b0, '0);
    cyc;
    HRESETn = 1'b1;

    // Parked owner M0: zero-wait back-to-back reads.
    for (int k = 0; k < 4; k++) begin
      cyc;
      drv(0, 2'b10, 32'h100 + 32'(4 * k), 1'b0, '0);
      push(32'h100 + 32'(4 * k), 1'b0, '0);
      settle;
      chk("park_haddr", 64'(HADDR), 64'(32'h100 + 32'(4 * k)));
      chk("park_hready_m0", 64'(hready_m[0]), 64'd1);
      chk("hrdata_bcast", 64'(m_rdata[k % 3]), 64'(s_rdata));
    end
    cyc;
    m_trans[0] = 2'b00;
    settle;
    chk("park_idle_htrans", 64'(HTRANS), 64'(2'b00));

    // Three-way contention: order 0,1,2 with data one cycle behind each.
    cyc;
    drv(0, 2'b10, 32'h0, 1'b1, 64'hA);
    drv(1, 2'b10, 32'h4, 1'b1, 64'hB);
    drv(2, 2'b10, 32'h8, 1'b1, 64'hC);
    push(32'h0, 1'b1, 64'hA);
    push(32'h4, 1'b1, 64'hB);
    push(32'h8, 1'b1, 64'hC);
    settle;
    chk("cont0_haddr", 64'(HADDR), 64'(32'h0));
    chk("cont0_hready_m", 64'(hready_m), 64'(3'b111));
    cyc;
    for (int m = 0; m < 3; m++) m_trans[m] = 2'b00;
    settle;
    chk("cont1_haddr", 64'(HADDR), 64'(32'h4));
    chk("cont1_hready_m", 64'(hready_m), 64'(3'b001));
    cyc;
    settle;
    chk("cont2_haddr", 64'(HADDR), 64'(32'h8));
    chk("cont2_hready_m", 64'(hready_m), 64'(3'b011));
    cyc;
    settle;
    chk("cont3_htrans", 64'(HTRANS), 64'(2'b00));
    chk("cont3_hready_m", 64'(hready_m), 64'(3'b111));

    // Slave wait states during M1's data phase while M2 requests.
    cyc;
    drv(1, 2'b10, 32'h200, 1'b0, '0);
    push(32'h200, 1'b0, '0);
    settle;
    chk("wait_cap_htrans", 64'(HTRANS), 64'(2'b00));
    chk("wait_cap_hready_m1", 64'(hready_m[1]), 64'd1);
    cyc;
    drv(1, 2'b10, 32'h204, 1'b0, '0);
    push(32'h204, 1'b0, '0);
    settle;
    chk("wait_pend_haddr", 64'(HADDR), 64'(32'h200));
    chk("wait_pend_hready_m1", 64'(hready_m[1]), 64'd0);
    cyc;
    s_hready = 1'b0;
    drv(2, 2'b10, 32'h300, 1'b1, 64'hD);
    push(32'h300, 1'b1, 64'hD);
    settle;
    chk("wait_m2_hready", 64'(hready_m[2]), 64'd1);
    for (int w = 0; w < 3; w++) begin
      if (w > 0) begin
        cyc;
        m_trans[2] = 2'b00;
        settle;
        chk("wait_m2_stalled", 64'(hready_m[2]), 64'd0);
      end
      chk("wait_haddr", 64'(HADDR), 64'(32'h204));
      chk("wait_htrans", 64'(HTRANS), 64'(2'b10));
      chk("wait_hready_m1", 64'(hready_m[1]), 64'd0);
    end
    cyc;
    s_hready = 1'b1;
    settle;
    chk("wait_end_haddr", 64'(HADDR), 64'(32'h204));
    chk("wait_end_hready_m1", 64'(hready_m[1]), 64'd1);
    cyc;
    m_trans[1] = 2'b00;
    settle;
    chk("wait_m2_haddr", 64'(HADDR), 64'(32'h300));
    chk("wait_m2_hwrite", 64'(HWRITE), 64'd1);
    chk("wait_m2_hready", 64'(hready_m[2]), 64'd0);
    cyc;
    settle;
    chk("wait_m2_done", 64'(hready_m[2]), 64'd1);

    // BUSY is never captured or forwarded.
    cyc;
    drv(0, 2'b01, 32'h500, 1'b0, '0);
    drv(2, 2'b01, 32'h400, 1'b0, '0);
    for (int b = 0; b < 2; b++) begin
      settle;
      chk("busy_htrans", 64'(HTRANS), 64'(2'b00));
      chk("busy_hready_m", 64'(hready_m), 64'(3'b111));
      cyc;
    end
    m_trans[0] = 2'b00;
    m_trans[2] = 2'b00;

    // Fairness: M0 and M1 saturate; issue order must alternate 0,1,0,1...
    for (int k = 0; k < 5; k++) begin
      push(32'h600 + 32'(4 * k), 1'b0, '0);
      push(32'h700 + 32'(4 * k), 1'b0, '0);
    end
    idx[0] = 0;
    idx[1] = 0;
    for (int c = 0; c < 40 && (idx[0] < 5 || idx[1] < 5); c++) begin
      cyc;
      for (int m = 0; m < 2; m++) begin
        if (idx[m] < 5) drv(m, 2'b10, (m == 0 ? 32'h600 : 32'h700) + 32'(4 * idx[m]), 1'b0, '0);
        else            m_trans[m] = 2'b00;
      end
      settle;
      for (int m = 0; m < 2; m++)
        if (m_trans[m][1] && hready_m[m]) idx[m]++;
    end
    cyc;
    m_trans[0] = 2'b00;
    m_trans[1] = 2'b00;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) cyc;
    cyc;
    chk("fair_drain", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset with M1 and M2 pending behind a stalled slave.
    cyc;
    s_hready = 1'b0;
    drv(1, 2'b10, 32'h800, 1'b0, '0);
    drv(2, 2'b10, 32'h900, 1'b0, '0);
    settle;
    chk("arst_pre_hready_m", 64'(hready_m), 64'(3'b111));
    cyc;
    m_trans[1] = 2'b00;
    m_trans[2] = 2'b00;
    #1;
    chk("arst_pend_hready_m", 64'(hready_m), 64'(3'b001));
    chk("arst_pend_htrans", 64'(HTRANS), 64'(2'b10));
    HRESETn = 1'b0;
    #1;
    chk("arst_hready_m", 64'(hready_m), 64'(3'b111));
    chk("arst_htrans", 64'(HTRANS), 64'(2'b00));
    chk("arst_hwdata", 64'(HWDATA), 64'(0));
    cyc;
    cyc;
    HRESETn  = 1'b1;
    s_hready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cyc;
      settle;
      chk("post_rst_htrans", 64'(HTRANS), 64'(2'b00));
      chk("post_rst_hready_m", 64'(hready_m), 64'(3'b111));
    end
    chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
